// File: rtl/up_down_counter_p.sv
// Parametrised up/down counter with step, load, boundary event and sticky flags.
// Define UDC_SATURATE_EN to clamp at the boundaries instead of wrapping modulo MAX_VAL+1.
module up_down_counter_p #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}},
  parameter int                 STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              evt,
  output logic              ovf,
  output logic              unf
);

  // One extra bit so the up-sum and the modulus (2**WIDTH when MAX_VAL is all ones) fit.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + 1'b1;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             up_cross;
  logic             dn_cross;
  logic             stepping;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] count_next;
  logic             evt_next;
  logic             set_ovf;
  logic             set_unf;

  always_comb begin
    cnt_ext  = {1'b0, count};
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    sum      = cnt_ext + step_ext;
    diff     = cnt_ext - step_ext;
    // At a boundary with step >= 1 these compares already fire, so saturate mode
    // needs no special case for "step attempted while at the boundary".
    up_cross = (sum > MAX_EXT);
    dn_cross = (step_ext > cnt_ext);
    stepping = en && !load;
    load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

`ifdef UDC_SATURATE_EN
  always_comb begin
    up_next = up_cross ? MAX_VAL : sum[WIDTH-1:0];
    dn_next = dn_cross ? '0 : diff[WIDTH-1:0];
  end
`else
  logic [WIDTH:0] up_wrap;
  logic [WIDTH:0] dn_wrap;

  always_comb begin
    up_wrap = sum - MOD_EXT;
    dn_wrap = cnt_ext + MOD_EXT - step_ext;
    up_next = up_cross ? up_wrap[WIDTH-1:0] : sum[WIDTH-1:0];
    dn_next = dn_cross ? dn_wrap[WIDTH-1:0] : diff[WIDTH-1:0];
  end
`endif

  always_comb begin
    count_next = count;
    evt_next   = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (load) begin
      count_next = load_sat;
    end else if (stepping) begin
      if (!in) begin
        count_next = up_next;
        evt_next   = up_cross;
        set_ovf    = up_cross;
      end else begin
        count_next = dn_next;
        evt_next   = dn_cross;
        set_unf    = dn_cross;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      evt   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_next;
      evt   <= evt_next;
      // A new crossing on the same edge as clr_flags keeps the flag set.
      ovf   <= (ovf && !clr_flags) || set_ovf;
      unf   <= (unf && !clr_flags) || set_unf;
    end
  end

endmodule

// File: tb/tb_up_down_counter_p.sv
// Bench for up_down_counter_p: three instances (MAX_VAL 255, 9, 150) driven in parallel
// and compared every cycle against an integer reference model, plus directed checks.
module tb_up_down_counter_p;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, clr_flags;
  logic [3:0] step;
  logic [7:0] load_val;
  logic [7:0] cnt_o [3];
  logic       evt_o [3];
  logic       ovf_o [3];
  logic       unf_o [3];

  int tests  = 0;
  int failed = 0;

  int m_max [3] = '{255, 9, 150};
  int m_cnt [3];
  int m_evt [3];
  int m_ovf [3];
  int m_unf [3];

`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  up_down_counter_p #(.WIDTH(8), .MAX_VAL(8'd255), .STEP_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in(dir), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(cnt_o[0]), .evt(evt_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));

  up_down_counter_p #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(dir), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(cnt_o[1]), .evt(evt_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));

  up_down_counter_p #(.WIDTH(8), .MAX_VAL(8'd150), .STEP_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(dir), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(cnt_o[2]), .evt(evt_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: apply the operation rules directly on integers.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_evt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        m_evt[i] = 0;
        if (clr_flags) begin m_ovf[i] = 0; m_unf[i] = 0; end
        if (load) begin
          m_cnt[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
        end else if (en && step != 0) begin
          if (!dir) begin
            if (m_cnt[i] + int'(step) <= m_max[i]) m_cnt[i] = m_cnt[i] + int'(step);
            else begin
              m_evt[i] = 1; m_ovf[i] = 1;
              m_cnt[i] = SAT ? m_max[i] : m_cnt[i] + int'(step) - (m_max[i] + 1);
            end
          end else begin
            if (int'(step) <= m_cnt[i]) m_cnt[i] = m_cnt[i] - int'(step);
            else begin
              m_evt[i] = 1; m_unf[i] = 1;
              m_cnt[i] = SAT ? 0 : m_cnt[i] + (m_max[i] + 1) - int'(step);
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count%0d", i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("evt%0d", i),   int'(evt_o[i]), m_evt[i]);
      check($sformatf("ovf%0d", i),   int'(ovf_o[i]), m_ovf[i]);
      check($sformatf("unf%0d", i),   int'(unf_o[i]), m_unf[i]);
    end
  endtask

  task automatic idle();
    rst = 0; en = 0; dir = 0; step = 0; load = 0; load_val = 0; clr_flags = 0;
  endtask

  int saved;

  initial begin
    idle();
    rst = 1;
    cycle();
    check("reset_count", int'(cnt_o[0]), 0);
    check("reset_ovf", int'(ovf_o[0]), 0);
    rst = 0;

    // Up count by 1 for 10 cycles, then reset mid-run.
    en = 1; step = 1; dir = 0;
    repeat (10) cycle();
    check("up10_count", int'(cnt_o[0]), 10);
    check("up10_ovf", int'(ovf_o[0]), 0);
    rst = 1;
    cycle();
    check("midrun_reset", int'(cnt_o[0]), 0);
    rst = 0;

    // Decade counter: 3,6,9 then crossing.
    step = 3;
    repeat (3) cycle();
    check("dec_9", int'(cnt_o[1]), 9);
    check("dec_evt_low", int'(evt_o[1]), 0);
    cycle();
    check("dec_cross_count", int'(cnt_o[1]), SAT ? 9 : 2);
    check("dec_cross_evt", int'(evt_o[1]), 1);
    check("dec_cross_ovf", int'(ovf_o[1]), 1);
    if (!SAT) begin
      dir = 1; step = 4;
      cycle();
      check("dec_down_count", int'(cnt_o[1]), 8);
      check("dec_down_unf", int'(unf_o[1]), 1);
      check("dec_down_evt", int'(evt_o[1]), 1);
    end

    // Load clamp and load-over-enable priority.
    idle();
    load = 1; load_val = 200;
    cycle();
    check("load_clamp", int'(cnt_o[2]), 150);
    load_val = 20; en = 1; step = 5; dir = 0;
    cycle();
    check("load_wins", int'(cnt_o[2]), 20);
    load = 0; en = 0;
    cycle();
    check("evt_after_load", int'(evt_o[2]), 0);

    // Sticky flag: set wins over clear, then clear alone.
    idle();
    clr_flags = 1;
    cycle();
    clr_flags = 0; load = 1; load_val = 1;
    cycle();
    load = 0; en = 1; dir = 1; step = 3;
    cycle();
    check("unf_set", int'(unf_o[1]), 1);
    step = 10; clr_flags = 1;
    cycle();
    check("unf_set_wins", int'(unf_o[1]), 1);
    en = 0;
    cycle();
    check("unf_cleared", int'(unf_o[1]), 0);

    // Hold with en low, then en high with step 0.
    idle();
    load = 1; load_val = 77;
    cycle();
    load = 0;
    saved = m_cnt[0];
    repeat (5) begin
      dir = 1'($urandom); step = 4'($urandom);
      cycle();
      check("hold_en0", int'(cnt_o[0]), saved);
      check("hold_en0_evt", int'(evt_o[0]), 0);
    end
    en = 1; step = 0;
    cycle();
    check("hold_step0", int'(cnt_o[0]), saved);

    if (SAT) begin
      idle();
      load = 1; load_val = 250;
      cycle();
      load = 0; en = 1; step = 15; dir = 0;
      cycle();
      check("sat_up_count", int'(cnt_o[0]), 255);
      check("sat_up_evt", int'(evt_o[0]), 1);
      check("sat_up_ovf", int'(ovf_o[0]), 1);
      cycle();
      check("sat_hold_count", int'(cnt_o[0]), 255);
      check("sat_hold_evt", int'(evt_o[0]), 1);
      en = 0; load = 1; load_val = 5;
      cycle();
      load = 0; en = 1; dir = 1;
      cycle();
      check("sat_dn_count", int'(cnt_o[0]), 0);
      check("sat_dn_unf", int'(unf_o[0]), 1);
    end

    // Randomised traffic; step kept within the smallest modulus (10).
    repeat (400) begin
      rst       = ($urandom_range(0, 99) < 2);
      load      = ($urandom_range(0, 99) < 10);
      load_val  = 8'($urandom);
      en        = ($urandom_range(0, 99) < 75);
      dir       = 1'($urandom);
      step      = 4'($urandom_range(0, 10));
      clr_flags = ($urandom_range(0, 99) < 8);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
